// File: rtl/ram8_dma.sv
// ram8_dma: block-move initiator for one port of the 8-bit x 2K dual-port RAM.
// Accepts copy (src->dst) and fill (dst <= byte) commands over valid/ready and
// sequences the RAM accesses: copy takes 2 cycles per byte (read, write), fill 1.
// Optional feature macro: RAM8_DMA_CSUM_EN enables a running modulo-2**DATA_W
// checksum of every written byte on csum_o; without it csum_o is tied to zero.
module ram8_dma #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_src_i,
  input  logic [ADDR_W-1:0] cmd_dst_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [DATA_W-1:0] cmd_fill_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic [DATA_W-1:0] csum_o
);

  // Largest legal transfer: the whole RAM.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;

  // Registered output copies, computed from the next state so that every
  // RAM-side control comes straight out of a flop.
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              din_sel_q, din_sel_d;   // 1: write data is the RAM read data
  logic [DATA_W-1:0] din_reg_q, din_reg_d;   // fill byte during FILL, else zero

  logic [LEN_W-1:0]  len_clamped_s;
  logic              accept_s;

  // Clamp oversize lengths to a full-RAM transfer.
  always_comb begin
    if (cmd_len_i > MAX_LEN) begin
      len_clamped_s = MAX_LEN;
    end else begin
      len_clamped_s = cmd_len_i;
    end
  end

  assign accept_s = (state_q == S_IDLE) && cmd_valid_i;

  // Next-state and datapath-register logic for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          src_d  = cmd_src_i;
          dst_d  = cmd_dst_i;
          cnt_d  = len_clamped_s;
          fill_d = cmd_fill_i;
          if (len_clamped_s == '0) begin
            state_d = S_DONE;
          end else if (cmd_op_i) begin
            state_d = S_FILL;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        state_d = S_WR;
      end
      S_WR: begin
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
        end
      end
      S_FILL: begin
        dst_d = dst_q + ADDR_W'(1);
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state; addresses are zero outside accesses.
  always_comb begin
    ready_d   = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    we_d      = (state_d == S_WR) || (state_d == S_FILL);
    din_sel_d = (state_d == S_WR);
    case (state_d)
      S_RD: begin
        addr_d    = src_d;
        din_reg_d = '0;
      end
      S_WR: begin
        addr_d    = dst_d;
        din_reg_d = '0;
      end
      S_FILL: begin
        addr_d    = dst_d;
        din_reg_d = fill_d;
      end
      default: begin
        addr_d    = '0;
        din_reg_d = '0;
      end
    endcase
  end

  // Sequencer state, datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      fill_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_sel_q <= 1'b0;
      din_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_sel_q <= din_sel_d;
      din_reg_q <= din_reg_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  // The copied byte only exists on mem_q in the WR cycle, so it is forwarded.
  assign mem_din_o   = din_sel_q ? mem_q_i : din_reg_q;

`ifdef RAM8_DMA_CSUM_EN
  logic [DATA_W-1:0] csum_q;

  // Running checksum: cleared on accept, accumulates each written byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csum_q <= '0;
    end else if (accept_s) begin
      csum_q <= '0;
    end else if (we_q) begin
      csum_q <= csum_q + mem_din_o;
    end else begin
      csum_q <= csum_q;
    end
  end

  assign csum_o = csum_q;
`else
  assign csum_o = '0;
`endif

endmodule

// File: tb/tb_ram8_dma.sv
// Directed bench for ram8_dma with a behavioural synchronous RAM on its port.
module tb_ram8_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [10:0] cmd_src;
  logic [10:0] cmd_dst;
  logic [11:0] cmd_len;
  logic [7:0]  cmd_fill;
  logic        busy;
  logic        done;
  logic [10:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_q;
  logic [7:0]  csum;

  logic        pre_we;
  logic [10:0] pre_addr;
  logic [7:0]  pre_din;
  logic [7:0]  ram [0:2047];

  int checks = 0;
  int errors = 0;
  int done_at;
  logic [7:0] csum_exp;

  always #5 clk = ~clk;

  ram8_dma dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_src_i   (cmd_src),
    .cmd_dst_i   (cmd_dst),
    .cmd_len_i   (cmd_len),
    .cmd_fill_i  (cmd_fill),
    .busy_o      (busy),
    .done_o      (done),
    .mem_addr_o  (mem_addr),
    .mem_din_o   (mem_din),
    .mem_we_o    (mem_we),
    .mem_q_i     (mem_q),
    .csum_o      (csum)
  );

  // RAM model: registered read (read-first), bench preload port has priority.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_din;
    else if (mem_we) ram[mem_addr] <= mem_din;
    mem_q <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_din = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [10:0] s, input logic [10:0] d,
                       input logic [11:0] l, input logic [7:0] f);
    cmd_op = op; cmd_src = s; cmd_dst = d; cmd_len = l; cmd_fill = f;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_fill = '0; pre_we = 1'b0; pre_addr = '0; pre_din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1); check("rst_busy", busy, 0);
    check("rst_done", done, 0);       check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);   check("rst_din", mem_din, 0);
    check("rst_csum", csum, 0);

    // 1: fill 0x010 x4 with A5
    issue(1'b1, 11'h000, 11'h010, 12'd4, 8'hA5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t1_we", mem_we, 1);
      check("t1_addr", mem_addr, 32'h10 + k - 1);
      check("t1_din", mem_din, 8'hA5);
      check("t1_done_early", done, 0);
    end
    @(negedge clk);
    check("t1_done", done, 1); check("t1_busy_done", busy, 1); check("t1_we_done", mem_we, 0);
    @(negedge clk);
    check("t1_busy_after", busy, 0); check("t1_ready_after", cmd_ready, 1);
    for (int i = 0; i < 4; i++) check("t1_ram", ram[11'h010 + i], 8'hA5);

    // 2: copy 000..002 -> 100..102
    preload(11'h000, 8'h11); preload(11'h001, 8'h22); preload(11'h002, 8'h33);
    issue(1'b0, 11'h000, 11'h100, 12'd3, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("t2_addr", mem_addr, (k % 2 == 1) ? (k - 1) / 2 : 32'h100 + (k / 2) - 1);
      check("t2_we", mem_we, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) check("t2_din", mem_din, 32'h11 * (k / 2));
      check("t2_done_early", done, 0);
    end
    @(negedge clk);
    check("t2_done7", done, 1);
    @(negedge clk);
    check("t2_ram0", ram[11'h100], 8'h11); check("t2_ram1", ram[11'h101], 8'h22);
    check("t2_ram2", ram[11'h102], 8'h33);

    // 3: fill wrapping past 0x7FF
    issue(1'b1, 11'h000, 11'h7FE, 12'd4, 8'h5A);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t3_addr", mem_addr, (32'h7FE + k - 1) % 32'h800);
      check("t3_we", mem_we, 1);
    end
    @(negedge clk);
    check("t3_done", done, 1);
    @(negedge clk);
    check("t3_busy_after", busy, 0);
    check("t3_ram7ff", ram[11'h7FF], 8'h5A); check("t3_ram001", ram[11'h001], 8'h5A);

    // 4: len=0 with a second command held on valid
    cmd_op = 1'b0; cmd_src = 11'h000; cmd_dst = 11'h200; cmd_len = 12'd0; cmd_fill = 8'h00;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 1'b1; cmd_dst = 11'h200; cmd_len = 12'd1; cmd_fill = 8'h77;
    @(negedge clk);
    check("t4_done", done, 1); check("t4_ready_busy", cmd_ready, 0); check("t4_we0", mem_we, 0);
    @(negedge clk);
    check("t4_ready_idle", cmd_ready, 1); check("t4_busy_idle", busy, 0);
    check("t4_we_idle", mem_we, 0); check("t4_done_idle", done, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t4_held_we", mem_we, 1); check("t4_held_addr", mem_addr, 32'h200);
    check("t4_held_din", mem_din, 8'h77);
    @(negedge clk);
    check("t4_held_done", done, 1);
    @(negedge clk);
    check("t4_ram", ram[11'h200], 8'h77);

    // Clamp: oversize length becomes a full 2048-byte fill
    issue(1'b1, 11'h000, 11'h000, 12'hFFF, 8'hEE);
    done_at = 0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (done) begin
        done_at = k;
        break;
      end
    end
    check("clamp_done_cycle", done_at, 2049);
    @(negedge clk);
    check("clamp_ram000", ram[11'h000], 8'hEE); check("clamp_ram7ff", ram[11'h7FF], 8'hEE);

    // 5: reset in the 3rd cycle of a len=8 fill
    preload(11'h303, 8'h00);
    issue(1'b1, 11'h000, 11'h300, 12'd8, 8'hC3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready", cmd_ready, 1); check("t5_busy", busy, 0);
    check("t5_we", mem_we, 0);       check("t5_csum", csum, 0);
    done_at = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) done_at = k;
    end
    check("t5_no_done", done_at, 0);
    check("t5_ram0", ram[11'h300], 8'hC3); check("t5_ram1", ram[11'h301], 8'hC3);
    check("t5_ram3", ram[11'h303], 8'h00);

    // 6: checksum of a copy of 80,90,10
    preload(11'h400, 8'h80); preload(11'h401, 8'h90); preload(11'h402, 8'h10);
    issue(1'b0, 11'h400, 11'h500, 12'd3, 8'h00);
    done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        done_at = k;
        break;
      end
    end
`ifdef RAM8_DMA_CSUM_EN
    csum_exp = 8'h20;
`else
    csum_exp = 8'h00;
`endif
    check("t6_done_cycle", done_at, 7);
    check("t6_csum", csum, csum_exp);
    @(negedge clk);
    check("t6_csum_hold", csum, csum_exp);
    check("t6_ram2", ram[11'h502], 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
